// File: rtl/sm_prog_ctrl_if.sv
// Host and SM-facing signal bundle for the SM program sequencer.
// slave is the sequencer's view; master is the host/SM side.
interface sm_prog_ctrl_if;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [12:0] wr_data;
  logic [10:0] prog_len;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  err_cnt;
  logic        res_valid;
  logic        res_ready;
  logic [22:0] res_data;
  logic        res_ovf;
  logic        sm_rst_n;
  logic [12:0] sm_instr;
  logic [9:0]  sm_pc;
  logic        sm_d_valid;
  logic [19:0] sm_out_data;
  logic [2:0]  sm_err_code;
  logic        sm_fin;

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, res_ready,
           sm_pc, sm_d_valid, sm_out_data, sm_err_code, sm_fin,
    output busy, done, status, err_cnt, res_valid, res_data, res_ovf,
           sm_rst_n, sm_instr
  );

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, res_ready,
           sm_pc, sm_d_valid, sm_out_data, sm_err_code, sm_fin,
    input  busy, done, status, err_cnt, res_valid, res_data, res_ovf,
           sm_rst_n, sm_instr
  );
endinterface

// File: rtl/sm_prog_ctrl.sv
// Program sequencer for the SM stack machine: instruction store, run control
// through SM's reset, watchdog timer and a result FIFO toward the host.
//
// state  | meaning
// IDLE   | SM held in reset, host may load the store and start a run
// RUN    | SM released, instructions served from sm_pc, results buffered
// DONE   | one-cycle end-of-run pulse, SM going back into reset
module sm_prog_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 100000
) (
  input logic           clk,
  input logic           rst_n,
  sm_prog_ctrl_if.slave bus
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_FIN = 2'b00;
  localparam logic [1:0] ST_PC  = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     plen_q, plen_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            ovf_q, ovf_d;
  logic            sm_rst_n_q, sm_rst_n_d;
  logic [FAW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FAW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FAW:0]    cnt_q, cnt_d;

  logic [12:0]     store_q [DEPTH];
  logic [22:0]     fifo_q  [FIFO_DEPTH];

  logic            store_we;
  logic            clr;
  logic            push;
  logic            pop;
  logic            full;
  logic            push_ok;

  // Run control: start latches the run, exits are prioritised fin > pc > timeout.
  always_comb begin
    state_d  = state_q;
    plen_d   = plen_q;
    tmr_d    = tmr_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          plen_d = bus.prog_len;
          tmr_d  = TW'(TIMEOUT - 1);
          if (bus.prog_len == '0) begin
            state_d  = S_DONE;
            status_d = ST_PC;
          end else begin
            state_d  = S_RUN;
            status_d = ST_FIN;
          end
        end
      end
      S_RUN: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        if (bus.sm_fin) begin
          state_d  = S_DONE;
          status_d = ST_FIN;
        end else if ({1'b0, bus.sm_pc} >= plen_q) begin
          state_d  = S_DONE;
          status_d = ST_PC;
        end else if (tmr_q == '0) begin
          state_d  = S_DONE;
          status_d = ST_TMO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    sm_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      plen_q     <= '0;
      tmr_q      <= '0;
      status_q   <= ST_FIN;
      sm_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      plen_q     <= plen_d;
      tmr_q      <= tmr_d;
      status_q   <= status_d;
      sm_rst_n_q <= sm_rst_n_d;
    end
  end

  assign store_we = (state_q == S_IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < 11'(DEPTH));

  always_ff @(posedge clk) begin
    if (store_we) store_q[bus.wr_addr[AW-1:0]] <= bus.wr_data;
  end

  assign bus.sm_instr = ((state_q == S_RUN) && ({1'b0, bus.sm_pc} < 11'(DEPTH)))
                        ? store_q[bus.sm_pc[AW-1:0]] : 13'h0000;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign clr     = (state_q == S_IDLE) && bus.start;
  assign push    = (state_q == S_RUN) && bus.sm_d_valid;
  assign pop     = (cnt_q != '0) && bus.res_ready;
  assign full    = (cnt_q == (FAW+1)'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      err_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (push && (bus.sm_err_code != 3'd0) && (err_cnt_q != 8'hFF))
        err_cnt_d = err_cnt_q + 8'd1;
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= {bus.sm_err_code, bus.sm_out_data};
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.status    = status_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_data  = (cnt_q != '0) ? fifo_q[rd_ptr_q] : 23'h0;
  assign bus.res_ovf   = ovf_q;
  assign bus.sm_rst_n  = sm_rst_n_q;

endmodule

// File: tb/tb_sm_prog_ctrl.sv
// Directed bench for sm_prog_ctrl: a vector table for the basic runs plus
// hand-written sequences for timeout, FIFO overflow and mid-run reset.
module tb_sm_prog_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sm_prog_ctrl_if bus ();

  sm_prog_ctrl #(.DEPTH(8), .FIFO_DEPTH(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        start;
    logic [10:0] plen;
    logic [9:0]  pc;
    logic        dv;
    logic [19:0] out;
    logic [2:0]  err;
    logic        fin;
    logic        rr;
    logic [12:0] e_instr;
    logic        e_busy;
    logic        e_done;
    logic [1:0]  e_status;
    logic        e_rv;
    logic [22:0] e_rdata;
    logic [7:0]  e_errcnt;
    logic        e_srst;
  } vec_t;

  vec_t        vq[$];
  logic [12:0] prg [3];

  function automatic vec_t mk(input logic st, input logic [10:0] pl, input logic [9:0] pc,
                              input logic dv, input logic [19:0] od, input logic [2:0] ec,
                              input logic fn, input logic rr, input logic [12:0] ei,
                              input logic eb, input logic ed, input logic [1:0] es,
                              input logic erv, input logic [22:0] erd, input logic [7:0] eec,
                              input logic esr);
    vec_t v;
    v.start = st; v.plen = pl; v.pc = pc; v.dv = dv; v.out = od; v.err = ec;
    v.fin = fn; v.rr = rr; v.e_instr = ei; v.e_busy = eb; v.e_done = ed;
    v.e_status = es; v.e_rv = erv; v.e_rdata = erd; v.e_errcnt = eec; v.e_srst = esr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [12:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic load_prog();
    for (int k = 0; k < 3; k++) wr(10'(k), prg[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] drain [8];
    int n;
    prg[0] = 13'h0003;
    prg[1] = 13'h0004;
    prg[2] = 13'h0400;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.prog_len = 0; bus.start = 0;
    bus.res_ready = 0; bus.sm_pc = 0; bus.sm_d_valid = 0; bus.sm_out_data = 0;
    bus.sm_err_code = 0; bus.sm_fin = 0;

    #3;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.status", bus.status, 0);
    chk("rst.err_cnt", bus.err_cnt, 0);
    chk("rst.ovf", bus.res_ovf, 0);
    chk("rst.res_valid", bus.res_valid, 0);
    chk("rst.res_data", bus.res_data, 0);
    chk("rst.sm_rst_n", bus.sm_rst_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_prog();

    // st plen pc dv out err fin rr | instr busy done status rv rdata errcnt srst
    vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 13'h0003, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 13'h0004, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 3, 2, 1, 7, 0, 0, 0, 13'h0400, 1, 0, 0, 1, 23'h000007, 0, 1));
    vq.push_back(mk(0, 3, 2, 0, 0, 0, 1, 0, 13'h0400, 1, 1, 0, 1, 23'h000007, 0, 0));
    vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0, 0, 1, 23'h000007, 0, 0));
    vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1, 13'h0000, 0, 0, 0, 0, 23'h0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 13'h0003, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 13'h0004, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 3, 2, 1, 7, 3, 0, 0, 13'h0400, 1, 0, 0, 1, 23'h300007, 1, 1));
    vq.push_back(mk(0, 3, 2, 0, 0, 0, 1, 0, 13'h0400, 1, 1, 0, 1, 23'h300007, 1, 0));
    vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1, 13'h0000, 0, 0, 0, 0, 23'h0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 1, 1, 0, 23'h0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0, 1, 0, 23'h0, 0, 0));
    vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 13'h0003, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 13'h0004, 1, 0, 0, 0, 23'h0, 0, 1));
    vq.push_back(mk(0, 2, 2, 1, 5, 0, 0, 0, 13'h0400, 1, 1, 1, 1, 23'h000005, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 0, 1, 1, 23'h000005, 0, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      bus.start = vq[i].start; bus.prog_len = vq[i].plen; bus.sm_pc = vq[i].pc;
      bus.sm_d_valid = vq[i].dv; bus.sm_out_data = vq[i].out; bus.sm_err_code = vq[i].err;
      bus.sm_fin = vq[i].fin; bus.res_ready = vq[i].rr;
      #1;
      chk($sformatf("v%0d.instr", i), bus.sm_instr, vq[i].e_instr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.busy", i), bus.busy, vq[i].e_busy);
      chk($sformatf("v%0d.done", i), bus.done, vq[i].e_done);
      chk($sformatf("v%0d.status", i), bus.status, vq[i].e_status);
      chk($sformatf("v%0d.res_valid", i), bus.res_valid, vq[i].e_rv);
      chk($sformatf("v%0d.res_data", i), bus.res_data, vq[i].e_rdata);
      chk($sformatf("v%0d.err_cnt", i), bus.err_cnt, vq[i].e_errcnt);
      chk($sformatf("v%0d.sm_rst_n", i), bus.sm_rst_n, vq[i].e_srst);
    end
    @(negedge clk);
    bus.start = 0; bus.sm_pc = 0; bus.sm_d_valid = 0; bus.sm_out_data = 0;
    bus.sm_err_code = 0; bus.sm_fin = 0; bus.res_ready = 0;

    // Watchdog: SM parked on pc 0, no fin.
    @(negedge clk);
    bus.start = 1; bus.prog_len = 3;
    @(posedge clk);
    #1;
    chk("tmo.res_clear", bus.res_valid, 0);
    chk("tmo.busy", bus.busy, 1);
    @(negedge clk);
    bus.start = 0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmo.cycles", n, 16);
    chk("tmo.status", bus.status, 2);
    @(posedge clk);
    #1;
    chk("tmo.idle", bus.busy, 0);

    // FIFO overflow, then push+pop while full, then ordered drain.
    @(negedge clk);
    bus.start = 1; bus.prog_len = 3; bus.sm_pc = 0; bus.res_ready = 0;
    @(negedge clk);
    bus.start = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        chk("fifo.ovf_at_full", bus.res_ovf, 0);
        chk("fifo.valid_at_full", bus.res_valid, 1);
      end
      bus.sm_d_valid = 1; bus.sm_out_data = 20'(100 + i);
      @(negedge clk);
    end
    chk("fifo.ovf", bus.res_ovf, 1);
    chk("fifo.head", bus.res_data, 23'd100);
    bus.sm_out_data = 20'd200; bus.res_ready = 1;
    @(negedge clk);
    chk("fifo.head_after_pp", bus.res_data, 23'd101);
    bus.sm_d_valid = 0; bus.res_ready = 0; bus.sm_fin = 1;
    @(negedge clk);
    chk("fifo.done", bus.done, 1);
    chk("fifo.status", bus.status, 0);
    bus.sm_fin = 0;
    for (int j = 0; j < 7; j++) drain[j] = 23'(101 + j);
    drain[7] = 23'd200;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d.valid", j), bus.res_valid, 1);
      chk($sformatf("drain%0d.data", j), bus.res_data, drain[j]);
      bus.res_ready = 1;
      @(negedge clk);
    end
    chk("drain.empty", bus.res_valid, 0);
    chk("drain.ovf_sticky", bus.res_ovf, 1);
    bus.res_ready = 0;

    // Store write attempt during RUN, then asynchronous reset mid-run.
    @(negedge clk);
    bus.start = 1; bus.prog_len = 3; bus.sm_pc = 0;
    @(negedge clk);
    bus.start = 0;
    chk("rstrun.ovf_clear", bus.res_ovf, 0);
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 13'h1FFF;
    bus.sm_d_valid = 1; bus.sm_out_data = 20'd9;
    @(negedge clk);
    bus.wr_en = 0; bus.sm_d_valid = 0;
    #1;
    chk("rstrun.wr_ignored", bus.sm_instr, 13'h0003);
    chk("rstrun.valid", bus.res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstrun.busy", bus.busy, 0);
    chk("rstrun.sm_rst_n", bus.sm_rst_n, 0);
    chk("rstrun.res_valid", bus.res_valid, 0);
    chk("rstrun.res_data", bus.res_data, 0);
    chk("rstrun.done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_prog();
    @(negedge clk);
    bus.start = 1; bus.prog_len = 3; bus.sm_pc = 0;
    @(negedge clk);
    bus.start = 0;
    #1;
    chk("rerun.sm_rst_n", bus.sm_rst_n, 1);
    for (int k = 0; k < 3; k++) begin
      bus.sm_pc = 10'(k); bus.sm_d_valid = (k == 2); bus.sm_out_data = 20'd7;
      #1;
      chk($sformatf("rerun.instr%0d", k), bus.sm_instr, prg[k]);
      @(negedge clk);
    end
    bus.sm_d_valid = 0; bus.sm_pc = 10'd9;
    #1;
    chk("rerun.instr_oob", bus.sm_instr, 13'h0000);
    @(posedge clk);
    #1;
    chk("rerun.done", bus.done, 1);
    chk("rerun.status", bus.status, 1);
    chk("rerun.res_data", bus.res_data, 23'h000007);
    @(posedge clk);
    #1;
    chk("rerun.sm_rst_n_off", bus.sm_rst_n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
